// File: rtl/i2c_seq_pkg.sv
// Shared types and helpers for the I2C packet sequencer: FSM state encoding,
// address/RW framing constants and the transmit byte selector.
package i2c_seq_pkg;

  localparam int   ADDR_W     = 7;
  localparam logic I2C_WR_BIT = 1'b0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_WAIT_START,
    S_LOAD,
    S_WAIT_BYTE,
    S_STOP,
    S_WAIT_STOP,
    S_DONE,
    S_ABORT
  } i2c_seq_state_e;

  // The first byte on the wire is the address with the write bit appended.
  function automatic logic [7:0] tx_byte_sel(input logic              is_addr,
                                             input logic [ADDR_W-1:0] addr,
                                             input logic [7:0]        payload);
    return is_addr ? {addr, I2C_WR_BIT} : payload;
  endfunction

endpackage

// File: rtl/i2c_tx_sequencer_rr_arbiter.sv
// Combinational round-robin pick: the first requester after ptr (with wrap)
// wins. The pointer register itself lives with the caller.
module rr_arbiter #(
  parameter int  REQS = 2,
  localparam int IW   = $clog2(REQS)
) (
  input  logic [REQS-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [REQS-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_vld
);

  // Scan from the farthest offset to the nearest so the nearest requester is written last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int off = REQS; off >= 1; off--) begin
      for (int i = 0; i < REQS; i++) begin
        if (req[i] && (((int'(ptr) + off) % REQS) == i)) begin
          gnt        = '0;
          gnt[i]     = 1'b1;
          gnt_idx    = IW'(i);
          gnt_vld    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/i2c_tx_sequencer.sv
// Packet-level write sequencer for a byte-level I2C master: round-robin grant,
// START, address byte, payload bytes, STOP, with timeout-driven abort.
module i2c_tx_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int  REQS      = 2,
  parameter int  MAX_BYTES = 4,
  parameter int  TIMEOUT   = 20000,
  localparam int LW        = $clog2(MAX_BYTES + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [REQS-1:0]             req,
  input  logic [REQS*ADDR_W-1:0]      req_addr,
  input  logic [REQS*LW-1:0]          req_len,
  input  logic [REQS*MAX_BYTES*8-1:0] req_data,
  output logic [REQS-1:0]             gnt,
  output logic [REQS-1:0]             done,
  output logic [REQS-1:0]             err,
  output logic                        busy,
  output logic [7:0]                  m_tx_data,
  output logic                        m_start,
  output logic                        m_stop,
  output logic                        m_i2c_en,
  output logic                        m_rst,
  input  logic                        m_ready,
  input  logic                        m_tx_done
);

  localparam int IW = $clog2(REQS);
  localparam int TW = $clog2(TIMEOUT);
  localparam int DW = MAX_BYTES * 8;

  i2c_seq_state_e state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     gsel_q, gsel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LW-1:0]     len_q, len_d;
  logic [DW-1:0]     data_q, data_d;
  logic [LW-1:0]     idx_q, idx_d;
  logic              seen_low_q, seen_low_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              tx_done_seen_q, tx_done_seen_d;

  logic [REQS-1:0] gnt_q, gnt_d;
  logic [REQS-1:0] done_q, done_d;
  logic [REQS-1:0] err_q, err_d;
  logic            busy_q, busy_d;
  logic [7:0]      m_tx_data_q, m_tx_data_d;
  logic            m_start_q, m_start_d;
  logic            m_stop_q, m_stop_d;
  logic            m_i2c_en_q, m_i2c_en_d;
  logic            m_rst_q, m_rst_d;

  logic [REQS-1:0]   arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_vld;
  logic [ADDR_W-1:0] sel_addr;
  logic [LW-1:0]     sel_len;
  logic [DW-1:0]     sel_data;
  logic              in_wait;
  logic              tmo_hit;
  logic              wait_exit;
  logic [REQS-1:0]   gsel_oh;
  logic [LW-1:0]     byte_ptr;
  logic [7:0]        payload;
  logic              status_unused;

  rr_arbiter #(.REQS(REQS)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Mux out the winning requester's packet; oversize lengths are clamped here.
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_data = '0;
    for (int i = 0; i < REQS; i++) begin
      if (arb_gnt[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_len  = req_len[i*LW +: LW];
        sel_data = req_data[i*DW +: DW];
      end
    end
    if (sel_len > LW'(MAX_BYTES)) begin
      sel_len = LW'(MAX_BYTES);
    end
  end

  assign in_wait   = (state_q == S_WAIT_START) || (state_q == S_WAIT_BYTE) ||
                     (state_q == S_STOP)       || (state_q == S_WAIT_STOP);
  assign tmo_hit   = in_wait && (tmo_q == TW'(TIMEOUT - 1));
  assign wait_exit = m_ready && seen_low_q;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    gsel_d         = gsel_q;
    addr_d         = addr_q;
    len_d          = len_q;
    data_d         = data_q;
    idx_d          = idx_q;
    seen_low_d     = seen_low_q | ~m_ready;
    tmo_d          = in_wait ? tmo_q + 1'b1 : '0;
    tx_done_seen_d = tx_done_seen_q | m_tx_done;

    case (state_q)
      S_IDLE: begin
        if (arb_vld) begin
          gsel_d  = arb_idx;
          ptr_d   = arb_idx;
          addr_d  = sel_addr;
          len_d   = sel_len;
          data_d  = sel_data;
          idx_d   = '0;
          state_d = S_START;
        end
      end
      S_START: state_d = S_WAIT_START;
      S_WAIT_START: begin
        if (wait_exit)    state_d = S_LOAD;
        else if (tmo_hit) state_d = S_ABORT;
      end
      S_LOAD: begin
        tx_done_seen_d = 1'b0;
        state_d        = S_WAIT_BYTE;
      end
      S_WAIT_BYTE: begin
        if (wait_exit) begin
          if (idx_q == len_q) begin
            state_d = S_STOP;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end else if (tmo_hit) begin
          state_d = S_ABORT;
        end
      end
      S_STOP: begin
        if (!m_ready)     state_d = S_WAIT_STOP;
        else if (tmo_hit) state_d = S_ABORT;
      end
      S_WAIT_STOP: begin
        if (wait_exit)    state_d = S_DONE;
        else if (tmo_hit) state_d = S_ABORT;
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Every state change restarts the timeout and the ready-low detector.
    if (state_d != state_q) begin
      tmo_d      = '0;
      seen_low_d = 1'b0;
    end
  end

  // Outputs are decoded from the next state so the registers line up with state_q.
  always_comb begin
    gsel_oh = '0;
    for (int i = 0; i < REQS; i++) begin
      if (gsel_d == IW'(i)) gsel_oh[i] = 1'b1;
    end

    byte_ptr = (idx_d == '0) ? '0 : idx_d - 1'b1;
    payload  = 8'h00;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (byte_ptr == LW'(k)) payload = data_q[k*8 +: 8];
    end

    gnt_d       = (state_d != S_IDLE) ? gsel_oh : '0;
    done_d      = '0;
    err_d       = '0;
    busy_d      = (state_d != S_IDLE);
    m_tx_data_d = m_tx_data_q;
    m_start_d   = 1'b0;
    m_stop_d    = 1'b0;
    m_i2c_en_d  = 1'b0;
    m_rst_d     = 1'b0;

    case (state_d)
      S_IDLE: m_tx_data_d = 8'hFF;
      S_START: begin
        m_start_d  = 1'b1;
        m_i2c_en_d = 1'b1;
      end
      S_WAIT_START: begin
        m_start_d  = ~seen_low_d;
        m_i2c_en_d = ~seen_low_d;
      end
      S_LOAD: begin
        m_tx_data_d = tx_byte_sel(idx_d == '0, addr_q, payload);
        m_i2c_en_d  = 1'b1;
      end
      S_STOP: begin
        m_stop_d   = 1'b1;
        m_i2c_en_d = 1'b1;
      end
      S_DONE:  done_d = gsel_oh;
      S_ABORT: begin
        err_d   = gsel_oh;
        m_rst_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ptr_q          <= IW'(REQS - 1);
      gsel_q         <= '0;
      addr_q         <= '0;
      len_q          <= '0;
      data_q         <= '0;
      idx_q          <= '0;
      seen_low_q     <= 1'b0;
      tmo_q          <= '0;
      tx_done_seen_q <= 1'b0;
      gnt_q          <= '0;
      done_q         <= '0;
      err_q          <= '0;
      busy_q         <= 1'b0;
      m_tx_data_q    <= 8'hFF;
      m_start_q      <= 1'b0;
      m_stop_q       <= 1'b0;
      m_i2c_en_q     <= 1'b0;
      m_rst_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gsel_q         <= gsel_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      data_q         <= data_d;
      idx_q          <= idx_d;
      seen_low_q     <= seen_low_d;
      tmo_q          <= tmo_d;
      tx_done_seen_q <= tx_done_seen_d;
      gnt_q          <= gnt_d;
      done_q         <= done_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
      m_tx_data_q    <= m_tx_data_d;
      m_start_q      <= m_start_d;
      m_stop_q       <= m_stop_d;
      m_i2c_en_q     <= m_i2c_en_d;
      m_rst_q        <= m_rst_d;
    end
  end

  // Byte-shifted status has no port; it is kept for waveform inspection.
  assign status_unused = tx_done_seen_q;

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign m_tx_data = m_tx_data_q;
  assign m_start   = m_start_q;
  assign m_stop    = m_stop_q;
  assign m_i2c_en  = m_i2c_en_q;
  assign m_rst     = m_rst_q;

endmodule

// File: tb/tb_i2c_tx_sequencer.sv
// Bench for i2c_tx_sequencer: behavioural byte-level master responder, round-robin
// and byte-stream reference model, directed plus randomized packets.
module tb_i2c_tx_sequencer;

  localparam int REQS      = 2;
  localparam int MAX_BYTES = 4;
  localparam int TIMEOUT   = 2000;
  localparam int LW        = 3;

  logic clk = 1'b0;
  logic reset;
  logic [REQS-1:0]             req;
  logic [REQS*7-1:0]           req_addr;
  logic [REQS*LW-1:0]          req_len;
  logic [REQS*MAX_BYTES*8-1:0] req_data;
  logic [REQS-1:0]             gnt, done, err;
  logic                        busy;
  logic [7:0]                  m_tx_data;
  logic                        m_start, m_stop, m_i2c_en, m_rst;
  logic                        m_ready   = 1'b1;
  logic                        m_tx_done = 1'b0;

  always #5 clk = ~clk;

  i2c_tx_sequencer #(.REQS(REQS), .MAX_BYTES(MAX_BYTES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_len(req_len),
    .req_data(req_data), .gnt(gnt), .done(done), .err(err), .busy(busy),
    .m_tx_data(m_tx_data), .m_start(m_start), .m_stop(m_stop), .m_i2c_en(m_i2c_en),
    .m_rst(m_rst), .m_ready(m_ready), .m_tx_done(m_tx_done)
  );

  // Master responder: 0 idle, 1 busy, 2 hold, 3 hung (no ACK)
  int       m_mode = 0;
  int       m_after = 0;
  int       m_cnt = 0;
  bit       first_byte = 1'b0;
  bit       nack_addr = 1'b0;
  int       bytes_seen = 0;
  logic [7:0] obs_q[$];

  always @(posedge clk) begin
    m_tx_done <= 1'b0;
    if (reset || m_rst) begin
      m_mode  <= 0;
      m_ready <= 1'b1;
    end else begin
      case (m_mode)
        0: if (m_start && m_i2c_en) begin
             m_mode <= 1; m_after <= 2; m_cnt <= $urandom_range(3, 8);
             m_ready <= 1'b0; first_byte <= 1'b1;
           end
        1: if (m_cnt <= 1) begin
             m_mode  <= m_after;
             m_ready <= (m_after != 3);
             m_tx_done <= (m_after != 0);
           end else begin
             m_cnt <= m_cnt - 1;
           end
        2: if (m_i2c_en && m_stop) begin
             m_mode <= 1; m_after <= 0; m_cnt <= $urandom_range(3, 8); m_ready <= 1'b0;
           end else if (m_i2c_en && !m_start) begin
             obs_q.push_back(m_tx_data);
             bytes_seen <= bytes_seen + 1;
             m_mode <= 1; m_after <= (nack_addr && first_byte) ? 3 : 2;
             m_cnt <= $urandom_range(3, 8); m_ready <= 1'b0; first_byte <= 1'b0;
           end
        default: ;
      endcase
    end
  end

  // Event monitor
  int done_order[$];
  int err_order[$];
  int rst_pulses = 0;
  int gnt_bad = 0;

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < REQS; i++) begin
        if (done[i]) done_order.push_back(i);
        if (err[i])  err_order.push_back(i);
      end
      if (m_rst) rst_pulses++;
      if ((busy != (gnt != '0)) || ($countones(gnt) > 1) || ((done & ~gnt) != '0) || ((err & ~gnt) != '0))
        gnt_bad++;
    end
  end

  // Reference model state
  int         checks = 0;
  int         failures = 0;
  int         rr_last;
  logic [6:0] pl_addr[REQS];
  int         pl_len[REQS];
  logic [7:0] pl_data[REQS][MAX_BYTES];
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [REQS-1:0] m);
    int c;
    for (int k = 1; k <= REQS; k++) begin
      c = (last + k) % REQS;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  task automatic push_exp(input int r);
    int n;
    n = (pl_len[r] > MAX_BYTES) ? MAX_BYTES : pl_len[r];
    exp_q.push_back({pl_addr[r], 1'b0});
    for (int k = 0; k < n; k++) exp_q.push_back(pl_data[r][k]);
  endtask

  task automatic apply_payloads();
    for (int r = 0; r < REQS; r++) begin
      req_addr[r*7 +: 7]   = pl_addr[r];
      req_len[r*LW +: LW]  = LW'(pl_len[r]);
      for (int k = 0; k < MAX_BYTES; k++) req_data[(r*MAX_BYTES+k)*8 +: 8] = pl_data[r][k];
    end
  endtask

  task automatic rand_payload(input int r);
    pl_addr[r] = 7'($urandom_range(0, 127));
    pl_len[r]  = $urandom_range(0, 7);
    for (int k = 0; k < MAX_BYTES; k++) pl_data[r][k] = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_gnt(output int gi);
    gi = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        for (int i = 0; i < REQS; i++) if (gnt[i]) gi = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      cyc++;
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic cmp_bytes(input string tag);
    chk({tag, "_nbytes"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"},   gnt, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_err"},   err, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_txd"},   m_tx_data, 8'hFF);
    chk({tag, "_start"}, m_start, 0);
    chk({tag, "_stop"},  m_stop, 0);
    chk({tag, "_en"},    m_i2c_en, 0);
    chk({tag, "_mrst"},  m_rst, 0);
  endtask

  // One packet: present mask, drop all requests right after the grant.
  task automatic run_pkt(input string tag, input logic [REQS-1:0] mask);
    int g, gi, d0, e0, cyc;
    bit ok;
    g  = rr_pick(rr_last, mask);
    push_exp(g);
    d0 = done_order.size();
    e0 = err_order.size();
    obs_q.delete();
    apply_payloads();
    req = mask;
    wait_gnt(gi);
    req = '0;
    chk({tag, "_gnt"}, gi, g);
    rr_last = g;
    wait_idle(ok, cyc);
    chk({tag, "_idle"}, ok, 1);
    cmp_bytes(tag);
    chk({tag, "_ndone"}, done_order.size(), d0 + 1);
    if (done_order.size() > 0) chk({tag, "_who"}, done_order[done_order.size()-1], g);
    chk({tag, "_nerr"}, err_order.size(), e0);
  endtask

  initial begin
    int  gi, n, cyc, d0, e0, r0, b0;
    bit  ok;
    int  exp_order[$];

    reset = 1'b1; req = '0; req_addr = '0; req_len = '0; req_data = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    rr_last = REQS - 1;
    repeat (2) @(negedge clk);

    // Both requesters held: order must alternate starting from 0
    rand_payload(0); rand_payload(1);
    obs_q.delete();
    for (int p = 0; p < 4; p++) begin
      gi = rr_pick(rr_last, 2'b11);
      exp_order.push_back(gi);
      push_exp(gi);
      rr_last = gi;
    end
    d0 = done_order.size();
    apply_payloads();
    req = 2'b11;
    n = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (done != '0) n++;
      if (n == 4) break;
    end
    req = '0;
    chk("rr_ndone", n, 4);
    wait_idle(ok, cyc);
    chk("rr_idle", ok, 1);
    cmp_bytes("rr");
    for (int p = 0; p < 4; p++)
      if (done_order.size() > d0 + p) chk($sformatf("rr_order%0d", p), done_order[d0+p], exp_order[p]);

    // Directed two-byte packet
    pl_addr[0] = 7'h3C; pl_len[0] = 2;
    pl_data[0][0] = 8'hA5; pl_data[0][1] = 8'h5A; pl_data[0][2] = 8'h11; pl_data[0][3] = 8'h22;
    run_pkt("t1", 2'b01);

    // Address-only packet
    pl_addr[0] = 7'h50; pl_len[0] = 0;
    run_pkt("t3", 2'b01);

    // Oversize length clamps to MAX_BYTES
    rand_payload(1); pl_len[1] = 7;
    run_pkt("clamp", 2'b10);

    // Address NACK: hung master, timeout, abort
    nack_addr = 1'b1;
    rand_payload(0);
    d0 = done_order.size(); e0 = err_order.size(); r0 = rst_pulses;
    apply_payloads();
    req = 2'b01;
    wait_gnt(gi);
    req = '0;
    chk("nack_gnt", gi, rr_pick(rr_last, 2'b01));
    rr_last = 0;
    wait_idle(ok, cyc);
    chk("nack_idle", ok, 1);
    chk("nack_slow", cyc >= TIMEOUT, 1);
    chk("nack_nerr", err_order.size(), e0 + 1);
    if (err_order.size() > 0) chk("nack_who", err_order[err_order.size()-1], 0);
    chk("nack_mrst", rst_pulses, r0 + 1);
    chk("nack_ndone", done_order.size(), d0);
    nack_addr = 1'b0;
    obs_q.delete(); exp_q.delete();
    rand_payload(0);
    run_pkt("after_nack", 2'b01);

    // Reset while a byte is in flight
    rand_payload(0); pl_len[0] = 4;
    d0 = done_order.size(); e0 = err_order.size();
    b0 = bytes_seen;
    apply_payloads();
    req = 2'b01;
    wait_gnt(gi);
    req = '0;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (bytes_seen > b0 && busy && !m_ready) begin ok = 1'b1; break; end
    end
    chk("mid_reached", ok, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("mid_rst");
    reset = 1'b0;
    rr_last = REQS - 1;
    repeat (6) @(negedge clk);
    chk("mid_ndone", done_order.size(), d0);
    chk("mid_nerr", err_order.size(), e0);
    chk("mid_busy", busy, 0);
    obs_q.delete(); exp_q.delete();

    // Pointer back at reset value: requester 0 first
    rand_payload(0); rand_payload(1);
    run_pkt("ptr_rst", 2'b11);

    // Requester 1 drops its request right after grant
    rand_payload(1);
    run_pkt("t6", 2'b10);

    // Randomized packets
    for (int p = 0; p < 8; p++) begin
      rand_payload(0); rand_payload(1);
      run_pkt($sformatf("rnd%0d", p), 2'($urandom_range(1, 3)));
    end

    chk("gnt_shape", gnt_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
